// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
// Shared NES CPU bus definitions used by the OAM DMA initiator:
//   - RW_READ / RW_WRITE : encoding of the CPU read/~write line
//   - ADDR_OAMDMA        : $4014, the register whose write triggers a DMA
//   - ADDR_OAMDATA       : $2004, the PPU OAM data port written by the DMA
//   - dma_state_t        : DMA sequencer states
//   - page_address()     : builds a CPU address from a page and byte index
// -----------------------------------------------------------------------------
package oam_dma_pkg;

  localparam logic        RW_READ      = 1'b1;
  localparam logic        RW_WRITE     = 1'b0;
  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  // The low byte is the index itself, so a page never carries into the next.
  function automatic logic [15:0] page_address(input logic [7:0] page,
                                               input logic [7:0] index);
    return {page, index};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// CPU-side OAM DMA initiator. A CPU write to $4014 (decoded upstream into
// i_cs_n) halts the CPU through RDY and copies the 256-byte page named by the
// written value into PPU OAM by alternating a read of {page,index} with a
// write of that byte to $2004. All state changes on the falling clock edge,
// like the CPU bus itself. Reads are kept on even cycles, so a transfer that
// starts on the wrong parity inserts one dummy read (ALIGN).
//
// Ports:
//   i_clk         system clock (falling-edge active)
//   i_reset_n     asynchronous active-low reset
//   i_cs_n        $4014 chip select, active-low
//   i_rw          CPU read/~write
//   i_cpu_data    CPU data bus, supplies the page number on trigger
//   i_mem_data    memory read data during DMA read cycles
//   o_rdy         CPU RDY, 0 halts the CPU
//   o_bus_master  1 while the DMA drives o_address/o_rw/o_data
//   o_address     DMA bus address
//   o_rw          DMA read/~write (1 = read)
//   o_data        DMA write data, holds its last value outside WRITE
//   o_busy        1 from trigger until the final write completes
// -----------------------------------------------------------------------------
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] OAMDATA_ADDR = ADDR_OAMDATA,
  parameter int          NUM_BYTES    = 256
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs_n,
  input  logic        i_rw,
  input  logic [7:0]  i_cpu_data,
  input  logic [7:0]  i_mem_data,
  output logic        o_rdy,
  output logic        o_bus_master,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_data,
  output logic        o_busy
);

  localparam logic [7:0] LAST_INDEX = 8'(NUM_BYTES - 1);

  dma_state_t  state_r;
  dma_state_t  state_next;
  logic [7:0]  index_r;
  logic [7:0]  index_next;
  logic [7:0]  page_r;
  logic [7:0]  page_next;
  logic        parity_r;

  logic        rdy_r;
  logic        bus_master_r;
  logic [15:0] address_r;
  logic        rw_r;
  logic [7:0]  data_r;
  logic        busy_r;

  logic        rdy_next;
  logic        bus_master_next;
  logic [15:0] address_next;
  logic        rw_next;
  logic [7:0]  data_next;
  logic        busy_next;

  // Next-state, counter and page logic of the DMA sequencer.
  always_comb begin
    state_next = state_r;
    index_next = index_r;
    page_next  = page_r;
    data_next  = data_r;
    case (state_r)
      IDLE: begin
        if (!i_cs_n && (i_rw == RW_WRITE)) begin
          page_next  = i_cpu_data;
          index_next = 8'd0;
          state_next = HALT;
        end else begin
          state_next = IDLE;
        end
      end
      HALT: begin
        // An odd HALT cycle means the following cycle is even: read at once.
        if (parity_r) begin
          state_next = READ;
        end else begin
          state_next = ALIGN;
        end
      end
      ALIGN: begin
        state_next = READ;
      end
      READ: begin
        // The byte read becomes the write data of the following cycle.
        data_next  = i_mem_data;
        state_next = WRITE;
      end
      WRITE: begin
        if (index_r == LAST_INDEX) begin
          state_next = IDLE;
        end else begin
          index_next = index_r + 8'd1;
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode of the upcoming state so the bus signals come from flops.
  always_comb begin
    rdy_next        = 1'b1;
    bus_master_next = 1'b0;
    address_next    = 16'h0000;
    rw_next         = RW_READ;
    busy_next       = 1'b0;
    case (state_next)
      IDLE: begin
        rdy_next = 1'b1;
      end
      HALT: begin
        rdy_next  = 1'b0;
        busy_next = 1'b1;
      end
      ALIGN: begin
        rdy_next        = 1'b0;
        busy_next       = 1'b1;
        bus_master_next = 1'b1;
        address_next    = OAMDATA_ADDR;
      end
      READ: begin
        rdy_next        = 1'b0;
        busy_next       = 1'b1;
        bus_master_next = 1'b1;
        address_next    = page_address(page_next, index_next);
      end
      WRITE: begin
        rdy_next        = 1'b0;
        busy_next       = 1'b1;
        bus_master_next = 1'b1;
        rw_next         = RW_WRITE;
        address_next    = OAMDATA_ADDR;
      end
      default: begin
        rdy_next = 1'b1;
      end
    endcase
  end

  // Sequencer state, cycle parity and registered bus outputs.
  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      index_r      <= 8'd0;
      page_r       <= 8'd0;
      parity_r     <= 1'b0;
      rdy_r        <= 1'b1;
      bus_master_r <= 1'b0;
      address_r    <= 16'h0000;
      rw_r         <= RW_READ;
      data_r       <= 8'h00;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next;
      index_r      <= index_next;
      page_r       <= page_next;
      parity_r     <= ~parity_r;
      rdy_r        <= rdy_next;
      bus_master_r <= bus_master_next;
      address_r    <= address_next;
      rw_r         <= rw_next;
      data_r       <= data_next;
      busy_r       <= busy_next;
    end
  end

  assign o_rdy        = rdy_r;
  assign o_bus_master = bus_master_r;
  assign o_address    = address_r;
  assign o_rw         = rw_r;
  assign o_data       = data_r;
  assign o_busy       = busy_r;

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- CPU-side OAM DMA initiator: bus master that copies one 256-byte CPU page into PPU sprite memory through repeated writes to the PPU OAMDATA register ($2004).
- Sits between the CPU bus arbiter and the PPU. Triggered by a CPU write to $4014. It halts the CPU via RDY and owns the CPU address/data bus for 513 or 514 cycles.

Parameters:
- OAMDATA_ADDR, 16'h2004, target address of every DMA write cycle.
- NUM_BYTES, 256, bytes transferred per trigger; must be a power of two, ≤256.

Ports:
- i_clk  in  1  system clock; all state updates on the falling edge, matching the CPU bus.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_cs_n  in  1  chip select for $4014, active-low.
- i_rw  in  1  CPU read/~write.
- i_cpu_data  in  8  CPU data bus; the page number is captured on a $4014 write.
- i_mem_data  in  8  data returned by memory during DMA read cycles.
- o_rdy  out  1  to CPU RDY; 0 halts the CPU.
- o_bus_master  out  1  1 = DMA drives o_address/o_rw/o_data.
- o_address  out  16  DMA bus address.
- o_rw  out  1  DMA read/~write (1 = read).
- o_data  out  8  DMA write data.
- o_busy  out  1  1 from trigger until the final write completes.

Behaviour:
- Reset values: o_rdy=1, o_bus_master=0, o_address=0, o_rw=1, o_data=0, o_busy=0. Internal state: state=IDLE, index=0, page=0, parity=0.
- Parity flop toggles every clock from reset; 0 = even cycle.
- Trigger condition: i_cs_n=0 and i_rw=0 at a falling edge while in IDLE.
  - Latch page=i_cpu_data, set index=0, go to HALT.
  - Triggers outside IDLE are ignored; the page is not re-latched.
- State machine:
  - IDLE: o_rdy=1, o_bus_master=0, o_busy=0. Wait for trigger.
  - HALT (1 cycle): o_rdy=0, o_busy=1, o_bus_master=0. Next state is READ if the next cycle is even, else ALIGN.
  - ALIGN (1 cycle): o_rdy=0, o_bus_master=1, o_rw=1, o_address=OAMDATA_ADDR (dummy read). Next state is READ.
  - READ: o_bus_master=1, o_rw=1, o_address={page,index}. Latch i_mem_data at the falling edge. Next state is WRITE. READ always falls on an even cycle.
  - WRITE: o_bus_master=1, o_rw=0, o_address=OAMDATA_ADDR, o_data=latched byte.
    - If index==NUM_BYTES-1: go to IDLE; o_rdy=1 and o_bus_master=0 from the next cycle.
    - Otherwise: index+1, go to READ.
- Total duration from the trigger edge to o_rdy=1 is 513 cycles (even alignment) or 514 cycles (odd alignment). Exactly NUM_BYTES writes occur.
- index is 8 bits and compares against NUM_BYTES-1. Address low byte = index, so there is no carry into page; page $FF reads $FF00-$FFFF.
- o_data holds its last value outside WRITE. o_address and o_rw are don't-care when o_bus_master=0; they are driven as 0/1 respectively.
- Reset mid-transfer: immediate return to reset values, bus released, o_rdy=1. A partial OAM update is acceptable.
- The PPU is not notified specially. Each write is a normal $2004 write, and OAMADDR auto-increment is the PPU's responsibility.

Decomposition:
- Shared NES bus package holds:
  - RW_READ/RW_WRITE constants.
  - Address constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004.
  - State enum {IDLE, HALT, ALIGN, READ, WRITE}.
- No sub-module; the single FSM plus the index counter is natural. Address decode of $4014 into i_cs_n lives in the top-level bus decoder.

Test Plan:
- Reset held, then released:
  - Initially: all outputs at reset values; o_rdy=1 and o_busy=0 for 10 cycles.
  - Trigger: write $02 on an even cycle, memory $0200+i returns i^$A5.
  - Response: o_rdy low for 513 cycles. Bus shows 256 pairs: (read $0200+i, write $2004 data i^$A5). The first write carries $A5 and the last carries $5A.
- Same trigger issued so the post-HALT cycle is odd: exactly one ALIGN dummy cycle, then READ $0200 on an even cycle. Total 514 cycles.
- Page $FF transfer: last read address is $FFFF, with no wrap to $0000. The next cycle after the final write has o_bus_master=0.
- Second $4014 write (data $07) during the transfer: ignored. All reads stay in the original page and duration is unchanged.
- Assert i_reset_n=0 at byte 100 of a transfer: asynchronously o_rdy=1, o_bus_master=0, o_busy=0. A subsequent trigger restarts at index 0.
